// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a multicycle RISC-V datapath
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [1:0] immsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic [2:0] alucontrol,
  output logic       adrsrc,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite
);
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_BEQ = 7'b1100011;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, ALUWB, EXECI, JAL, BEQ
  } state_t;
  state_t state, next;
  logic [1:0] aluop;
  logic pcupdate, branch, ir, rw, mw;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= FETCH;
    else state <= next;
  always_comb begin
    next = FETCH;
    case (state)
      FETCH:   next = DECODE;
      DECODE:  next = (op == OP_LW || op == OP_SW) ? MEMADR :
                      op == OP_R ? EXECR : op == OP_I ? EXECI :
                      op == OP_JAL ? JAL : op == OP_BEQ ? BEQ : FETCH;
      MEMADR:  next = op == OP_LW ? MEMREAD : MEMWRITE;
      MEMREAD: next = MEMWB;
      EXECR, EXECI, JAL: next = ALUWB;
      default: next = FETCH;
    endcase
  end
  always_comb begin
    adrsrc = 1'b0;
    ir = 1'b0;
    rw = 1'b0;
    mw = 1'b0;
    alusrca = 2'b00;
    alusrcb = 2'b00;
    resultsrc = 2'b00;
    aluop = 2'b00;
    pcupdate = 1'b0;
    branch = 1'b0;
    case (state)
      FETCH:    begin ir = 1'b1; alusrcb = 2'b10; resultsrc = 2'b10; pcupdate = 1'b1; end
      DECODE:   begin alusrca = 2'b01; alusrcb = 2'b01; end
      MEMADR:   begin alusrca = 2'b10; alusrcb = 2'b01; end
      MEMREAD:  adrsrc = 1'b1;
      MEMWB:    begin resultsrc = 2'b01; rw = 1'b1; end
      MEMWRITE: begin adrsrc = 1'b1; mw = 1'b1; end
      EXECR:    begin alusrca = 2'b10; aluop = 2'b10; end
      EXECI:    begin alusrca = 2'b10; alusrcb = 2'b01; aluop = 2'b10; end
      ALUWB:    rw = 1'b1;
      JAL:      begin alusrca = 2'b01; alusrcb = 2'b10; pcupdate = 1'b1; end
      BEQ:      begin alusrca = 2'b10; aluop = 2'b01; branch = 1'b1; end
      default:  ;
    endcase
  end
  // write enables are forced low during reset even though FETCH would assert them
  assign irwrite  = ir & ~reset;
  assign regwrite = rw & ~reset;
  assign memwrite = mw & ~reset;
  assign pcwrite  = (pcupdate | (branch & zero)) & ~reset;
  assign immsrc = (op == OP_SW) ? 2'b01 : (op == OP_BEQ) ? 2'b10 : (op == OP_JAL) ? 2'b11 : 2'b00;
  assign alucontrol = aluop == 2'b01 ? 3'b001 :
                      aluop != 2'b10 ? 3'b000 :
                      funct3 == 3'b000 ? {2'b00, op[5] & funct7b5} :
                      funct3 == 3'b010 ? 3'b101 :
                      funct3 == 3'b110 ? 3'b011 :
                      funct3 == 3'b111 ? 3'b010 : 3'b000;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: random instruction streams checked against a per-instruction cycle model
module tb_multicycle_controller;
  logic clk = 1'b0, reset = 1'b1;
  logic [6:0] op = 7'b0;
  logic [2:0] funct3 = 3'b0;
  logic funct7b5 = 1'b0, zero = 1'b0;
  logic [1:0] immsrc, alusrca, alusrcb, resultsrc;
  logic [2:0] alucontrol;
  logic adrsrc, irwrite, pcwrite, regwrite, memwrite;
  int total = 0, bad = 0;
  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .immsrc(immsrc), .alusrca(alusrca), .alusrcb(alusrcb), .resultsrc(resultsrc),
    .alucontrol(alucontrol), .adrsrc(adrsrc), .irwrite(irwrite), .pcwrite(pcwrite),
    .regwrite(regwrite), .memwrite(memwrite)
  );
  always #5 clk = ~clk;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;
  wire [15:0] obs = {adrsrc, irwrite, pcwrite, regwrite, memwrite,
                     alusrca, alusrcb, resultsrc, alucontrol, immsrc};
  function automatic int len(logic [6:0] o);
    return o == LW ? 5 : (o == SW || o == RT || o == IT || o == JL) ? 4 : o == BQ ? 3 : 2;
  endfunction
  function automatic logic [2:0] alu(logic [2:0] f3, logic sub);
    return f3 == 3'd0 ? {2'b00, sub} : f3 == 3'd2 ? 3'd5 : f3 == 3'd6 ? 3'd3 : f3 == 3'd7 ? 3'd2 : 3'd0;
  endfunction
  // expected outputs in cycle k of an instruction (k=0 is the fetch cycle)
  function automatic logic [15:0] model(logic [6:0] o, logic [2:0] f3, logic f7, logic z, int k, logic r);
    logic ad = 0, ir = 0, pw = 0, rw = 0, mw = 0;
    logic [1:0] sa = 0, sb = 0, rs = 0, im;
    logic [2:0] ac = 0;
    im = o == SW ? 2'd1 : o == BQ ? 2'd2 : o == JL ? 2'd3 : 2'd0;
    if (k == 0) begin ir = ~r; pw = ~r; sb = 2; rs = 2; end
    else if (k == 1) begin sa = 1; sb = 1; end
    else if (o == LW || o == SW) begin
      if (k == 2) begin sa = 2; sb = 1; end
      else if (k == 3) begin ad = 1; mw = (o == SW); end
      else begin rs = 1; rw = 1; end
    end else if (o == RT || o == IT) begin
      if (k == 2) begin sa = 2; sb = (o == IT) ? 2'd1 : 2'd0; ac = alu(f3, o[5] & f7); end
      else rw = 1;
    end else if (o == JL) begin
      if (k == 2) begin sa = 1; sb = 2; pw = 1; end
      else rw = 1;
    end else if (o == BQ) begin
      sa = 2; ac = 1; pw = z;
    end
    return {ad, ir, pw, rw, mw, sa, sb, rs, ac, im};
  endfunction
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask
  // zr: 0/1 fixed zero flag, 2 random per cycle; ab: cycle to abort with reset, -1 none
  task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7, input int zr, input int ab);
    op = o; funct3 = f3; funct7b5 = f7;
    for (int k = 0; k < len(o); k++) begin
      zero = zr == 2 ? 1'($urandom) : 1'(zr);
      #2 check($sformatf("op%b c%0d", o, k), obs, model(o, f3, f7, zero, k, 1'b0));
      if (k == ab) begin
        reset = 1'b1;
        #1 check($sformatf("abort op%b c%0d", o, k), obs, model(o, f3, f7, zero, 0, 1'b1));
        @(posedge clk); #1;
        check("abort hold", obs, model(o, f3, f7, zero, 0, 1'b1));
        reset = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
  endtask
  initial begin
    logic [6:0] o;
    logic [6:0] legal [6];
    legal = '{LW, SW, RT, IT, JL, BQ};
    #12 check("reset", obs, model(7'b0, 3'b0, 1'b0, 1'b0, 0, 1'b1));
    @(posedge clk); #1 check("reset edge", obs, model(7'b0, 3'b0, 1'b0, 1'b0, 0, 1'b1));
    reset = 1'b0;
    run(LW, 3'd2, 1'b0, 2, -1);
    run(SW, 3'd2, 1'b0, 2, -1);
    run(RT, 3'd0, 1'b1, 2, -1);
    run(RT, 3'd0, 1'b0, 2, -1);
    run(IT, 3'd0, 1'b1, 2, -1);
    run(BQ, 3'd0, 1'b0, 1, -1);
    run(BQ, 3'd0, 1'b0, 0, -1);
    run(JL, 3'd0, 1'b0, 2, -1);
    run(7'b1111111, 3'd0, 1'b0, 2, -1);
    run(SW, 3'd2, 1'b0, 2, 3);
    run(LW, 3'd2, 1'b0, 2, -1);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 6) == 0)
        do o = 7'($urandom); while (o == LW || o == SW || o == RT || o == IT || o == JL || o == BQ);
      else o = legal[$urandom_range(0, 5)];
      run(o, 3'($urandom), 1'($urandom), 2, $urandom_range(0, 24) < 5 ? $urandom_range(0, 4) : -1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have no parameters; state encoding is internal, 4 bits.
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: op  in  7  instr[6:0].
REQ-005 SHALL have port: funct3  in  3  instr[14:12].
REQ-006 SHALL have port: funct7b5  in  1  instr[30].
REQ-007 SHALL have port: zero  in  1  ALU zero flag.
REQ-008 SHALL have port: immsrc  out  2  immediate-extender select (00 I, 01 S, 10 B, 11 J).
REQ-009 SHALL have ports: alusrca  out  2; alusrcb  out  2; resultsrc  out  2; alucontrol  out  3.
REQ-010 SHALL have ports: adrsrc, irwrite, pcwrite, regwrite, memwrite  out  1 each.

Function
REQ-011 SHALL be a Moore FSM with states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, ALUWB, EXECI, JAL, BEQ.
REQ-012 SHALL transition on rising clk: FETCH->DECODE; MEMREAD->MEMWB; EXECR, EXECI, JAL->ALUWB; MEMWB, MEMWRITE, ALUWB, BEQ->FETCH.
REQ-013 SHALL leave DECODE by op: 0000011/0100011->MEMADR; 0110011->EXECR; 0010011->EXECI; 1101111->JAL; 1100011->BEQ; any other op->FETCH.
REQ-014 SHALL leave MEMADR to MEMREAD if op=0000011, else to MEMWRITE.
REQ-015 SHALL drive per state (unlisted outputs 0, aluop internal 2 bits):
 FETCH: adrsrc=0, irwrite=1, alusrca=00, alusrcb=10, aluop=00, resultsrc=10, pcupdate=1.
 DECODE: alusrca=01, alusrcb=01, aluop=00.
 MEMADR: alusrca=10, alusrcb=01, aluop=00.
 MEMREAD: resultsrc=00, adrsrc=1.  MEMWB: resultsrc=01, regwrite=1.
 MEMWRITE: resultsrc=00, adrsrc=1, memwrite=1.
 EXECR: alusrca=10, alusrcb=00, aluop=10.  EXECI: alusrca=10, alusrcb=01, aluop=10.
 ALUWB: resultsrc=00, regwrite=1.
 JAL: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcupdate=1.
 BEQ: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1.
REQ-016 SHALL compute pcwrite = pcupdate OR (branch AND zero), combinationally, same cycle.
REQ-017 SHALL decode immsrc combinationally from op regardless of state: 0000011/0010011->00, 0100011->01, 1100011->10, 1101111->11, other->00.
REQ-018 SHALL decode alucontrol combinationally: aluop 00->000 (add); 01->001 (sub); 10 by funct3: 000->001 if op[5]&funct7b5 else 000; 010->101 (slt); 110->011 (or); 111->010 (and); other funct3->000; aluop 11->000.
REQ-019 SHALL use op/funct3/funct7b5 only as presented each cycle; instruction register stability is the datapath's duty.
REQ-020 SHALL never reach an unlisted encoding; any illegal encoding SHALL next-state to FETCH.
REQ-021 SHALL complete instructions in: lw 5, sw 4, R 4, I 4, jal 4, beq 3, unknown op 2 cycles.

Reset
REQ-022 SHALL force state to FETCH asynchronously on reset rising, independent of clk.
REQ-023 SHALL hold irwrite, pcwrite, regwrite, memwrite at 0 while reset is 1; other outputs show FETCH values.
REQ-024 SHALL leave FETCH on the first rising clk after reset deasserts; reset mid-instruction SHALL abort it with no further write enable.

Verification
REQ-025 lw (op=0000011) from reset: states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; regwrite=1 only in cycle 5 with resultsrc=01; immsrc=00.
REQ-026 sw (op=0100011): memwrite=1 only in cycle 4, adrsrc=1; immsrc=01; regwrite never 1.
REQ-027 R-type sub (op=0110011, funct3=000, funct7b5=1): alucontrol=001 in EXECR; same with funct7b5=0 -> 000; I-type addi with funct7b5=1 -> 000.
REQ-028 beq with zero=1 -> pcwrite=1 in BEQ; zero=0 -> pcwrite=0; immsrc=10; alucontrol=001; 3 cycles.
REQ-029 jal (op=1101111): pcwrite=1 in JAL, regwrite=1 in following ALUWB, immsrc=11; op=1111111 returns DECODE->FETCH with no writes.
REQ-030 Assert reset mid-MEMWRITE between clk edges -> state FETCH immediately, memwrite drops to 0 same time step, all write enables 0 until release.
